if_id_queue: RTL



---
 rtl/if_id_queue.sv | 99 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry in-order instruction queue between fetch and decode.
// Each entry carries {instr, pc, ExcCode, bd}. An exception request flushes the
// whole queue; an eret at the head flushes everything once it advances.
//
// Handshake: on the fetch side an entry is transferred on a clock edge where
// push_valid && push_ready. push_ready depends only on occupancy, not on pop_en.
// On the decode side the head is consumed on an edge where pop_en && validD.
// A pop never frees a slot for a push in the same cycle.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              eretD,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] instrF,
  input  logic [DATA_W-1:0] pcF,
  input  logic [EXC_W-1:0]  ExcCodeF,
  input  logic              bdF,
  input  logic              pop_en,
  output logic [DATA_W-1:0] instrD,
  output logic [DATA_W-1:0] pcD,
  output logic [EXC_W-1:0]  ExcCodeD,
  output logic              bdD,
  output logic              validD,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;
  logic              flush;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign validD     = (count_q != '0);
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_en & validD;
  // An eret only commits (and discards younger entries) when decode advances.
  assign flush      = req | (eretD & pop_en);
  assign count      = count_q;
  assign head       = mem[rd_ptr];

  // Pointer and occupancy update; flushes take precedence over push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents are not cleared, occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) begin
      mem[wr_ptr] <= '{instr: instrF, pc: pcF, exc: ExcCodeF, bd: bdF};
    end
  end

  // Head presentation; forced to zero when the queue is empty.
  always_comb begin
    instrD   = '0;
    pcD      = '0;
    ExcCodeD = '0;
    bdD      = 1'b0;
    if (validD) begin
      instrD   = head.instr;
      pcD      = head.pc;
      ExcCodeD = head.exc;
      bdD      = head.bd;
    end
  end

endmodule
